// File: rtl/apb_sl_cmd_bridge.sv
// APB slave bridge: host writes become 34-bit command words, host reads pop response words.
// Optional interrupt output is enabled with `define SL_BRIDGE_IRQ_EN.
module apb_sl_cmd_bridge #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [4:0]  paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   input  logic        cmd_fifo_full,
   output logic [33:0] cmd_fifo_data,
   output logic        cmd_fifo_inc,
   input  logic        rsp_fifo_empty,
   input  logic [33:0] rsp_fifo_data,
   output logic        rsp_fifo_inc
`ifdef SL_BRIDGE_IRQ_EN
  ,output logic        irq
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [2:0] A_RSP  = 3'd4;
   localparam logic [2:0] A_MOD  = 3'd5;
   localparam logic [2:0] A_STAT = 3'd6;
   localparam logic [2:0] A_BAD  = 3'd7;

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   state_t           state, nxt_state;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic [1:0]       last_mod, nxt_last_mod;
   logic             err_sticky, nxt_err;
   logic             irq_en;
   logic [31:0]      nxt_prdata;
   logic             nxt_pready, nxt_pslverr;
   logic [33:0]      nxt_cmd_data;
   logic             nxt_cmd_inc, nxt_rsp_inc;

   logic [2:0]  sel;
   logic        is_push, is_pop, is_bad, is_stw, is_rd;
   logic        go;
   logic [31:0] rd_mux;
   logic        unused;

   assign unused = ^paddr[1:0];
   assign sel    = paddr[4:2];

   // Decode classes are mutually exclusive; writes to 0x10/0x14 fall through.
   assign is_push = pwrite & ~paddr[4];
   assign is_pop  = ~pwrite & (sel == A_RSP);
   assign is_bad  = (sel == A_BAD);
   assign is_stw  = pwrite & (sel == A_STAT);
   assign is_rd   = ~pwrite & ~is_pop & ~is_bad;

   assign go = (is_push & ~cmd_fifo_full)
             | (is_pop & ~rsp_fifo_empty)
             | (~is_push & ~is_pop);

   always_comb begin
      rd_mux = 32'd0;
      unique case (1'b1)
         (sel == A_MOD):  rd_mux = {30'd0, last_mod};
         (sel == A_STAT): rd_mux = {28'd0, irq_en, err_sticky,
                                    rsp_fifo_empty, cmd_fifo_full};
         default:         rd_mux = 32'd0;
      endcase
   end

`ifdef SL_BRIDGE_IRQ_EN
   logic nxt_irq_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         irq_en <= nxt_irq_en;
         irq    <= irq_en & (~rsp_fifo_empty | err_sticky);
      end
   end

   always_comb begin
      nxt_irq_en = irq_en;
      if (state == S_WAIT && psel && go && is_stw)
         nxt_irq_en = pwdata[3];
   end
`else
   assign irq_en = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         last_mod      <= 2'd0;
         err_sticky    <= 1'b0;
         prdata        <= 32'd0;
         pready        <= 1'b0;
         pslverr       <= 1'b0;
         cmd_fifo_data <= 34'd0;
         cmd_fifo_inc  <= 1'b0;
         rsp_fifo_inc  <= 1'b0;
      end else begin
         state         <= nxt_state;
         cnt           <= nxt_cnt;
         last_mod      <= nxt_last_mod;
         err_sticky    <= nxt_err;
         prdata        <= nxt_prdata;
         pready        <= nxt_pready;
         pslverr       <= nxt_pslverr;
         cmd_fifo_data <= nxt_cmd_data;
         cmd_fifo_inc  <= nxt_cmd_inc;
         rsp_fifo_inc  <= nxt_rsp_inc;
      end
   end

   always_comb begin
      nxt_state    = state;
      nxt_cnt      = cnt;
      nxt_last_mod = last_mod;
      nxt_err      = err_sticky;
      nxt_prdata   = prdata;
      nxt_pready   = 1'b0;
      nxt_pslverr  = 1'b0;
      nxt_cmd_data = cmd_fifo_data;
      nxt_cmd_inc  = 1'b0;
      nxt_rsp_inc  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (psel && !penable) begin
               nxt_state = S_WAIT;
               nxt_cnt   = '0;
            end
         end
         S_WAIT: begin
            if (!psel) begin
               nxt_state = S_IDLE;
            end else if (go) begin
               nxt_state  = S_DONE;
               nxt_pready = 1'b1;
               unique case (1'b1)
                  is_push: begin
                     nxt_cmd_inc  = 1'b1;
                     nxt_cmd_data = {paddr[3:2], pwdata};
                  end
                  is_pop: begin
                     nxt_rsp_inc  = 1'b1;
                     nxt_prdata   = rsp_fifo_data[31:0];
                     nxt_last_mod = rsp_fifo_data[33:32];
                  end
                  is_bad: begin
                     nxt_pslverr = 1'b1;
                     nxt_prdata  = 32'd0;
                  end
                  is_stw: begin
                     if (pwdata[2])
                        nxt_err = 1'b0;
                  end
                  is_rd: begin
                     nxt_prdata = rd_mux;
                  end
                  default: ;
               endcase
            end else if (cnt == TMO) begin
               // Stalled too long on FIFO full/empty: fail the access.
               nxt_state   = S_DONE;
               nxt_pready  = 1'b1;
               nxt_pslverr = 1'b1;
               nxt_prdata  = 32'd0;
               nxt_err     = 1'b1;
            end else begin
               nxt_cnt = cnt + 1'b1;
            end
         end
         S_DONE: begin
            nxt_state = S_IDLE;
         end
         default: begin
            nxt_state = S_IDLE;
         end
      endcase
   end

endmodule
